keypad_code_lock: RTL and testbench

Parametrised code-entry lock controller that sits between the keypad scanner and the LED-matrix/enable logic. It replaces the fixed digit checker and separate per-code on/off checkers. It accepts decoded key strobes and collects fixed-length entries. Each completed entry is matched against NUM_CODES programmable codes and drives a single registered enable/mode state. Repeated failures trigger a timed lockout, and stale partial entries are cleared by an inter-digit timeout.

---
 rtl/keypad_code_lock_if.sv | 36 +++
 rtl/keypad_code_lock.sv | 175 +++++++++++++++++
 tb/tb_keypad_code_lock.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_code_lock_if.sv
// ============================================================================
// Module   : keypad_code_lock_if
// Purpose  : Key-strobe, code-table and lock-status bundle for keypad_code_lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface keypad_code_lock_if #(
  parameter int CODE_LEN  = 4,
  parameter int NUM_CODES = 3
);
  localparam int MW  = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
  localparam int DCW = $clog2(CODE_LEN + 1);

  logic                            key_valid;
  logic [3:0]                      key_code;
  logic [NUM_CODES*CODE_LEN*4-1:0] codes;
  logic                            enabled;
  logic [MW-1:0]                   mode;
  logic                            match_pulse;
  logic                            fail_pulse;
  logic                            locked;
  logic [DCW-1:0]                  digit_count;

  modport master (
    output key_valid, key_code, codes,
    input  enabled, mode, match_pulse, fail_pulse, locked, digit_count
  );

  modport slave (
    input  key_valid, key_code, codes,
    output enabled, mode, match_pulse, fail_pulse, locked, digit_count
  );
endinterface

`default_nettype wire

// File: rtl/keypad_code_lock.sv
// ============================================================================
// Module   : keypad_code_lock
// Purpose  : Collects fixed-length key entries, matches them against a code
//            table to set enable mode, with fail lockout and digit timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_code_lock #(
  parameter int         CODE_LEN       = 4,
  parameter int         NUM_CODES      = 3,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 2**20,
  parameter int         DIGIT_TIMEOUT  = 2**18,
  parameter logic [3:0] CLEAR_KEY      = 4'hA,
  parameter int         MW             = $clog2(NUM_CODES)
) (
  input  logic               clk,
  input  logic               reset,
  keypad_code_lock_if.slave  bus
);

  localparam int DCW = $clog2(CODE_LEN + 1);
  localparam int FCW = (MAX_FAILS > 1) ? $clog2(MAX_FAILS + 1) : 1;
  localparam int TW  = (DIGIT_TIMEOUT > 1) ? $clog2(DIGIT_TIMEOUT) : 1;
  localparam int LW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [DCW-1:0] c_last_digit   = DCW'(CODE_LEN - 1);
  localparam logic [FCW-1:0] c_last_fail    = FCW'(MAX_FAILS - 1);
  localparam logic [TW-1:0]  c_timeout_last = TW'(DIGIT_TIMEOUT - 1);
  localparam logic [LW-1:0]  c_lock_last    = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ENTRY   = 2'd1,
    S_EVAL    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t                  r_state;
  logic [CODE_LEN*4-1:0]   r_buf;
  logic [DCW-1:0]          r_digit_count;
  logic [MW-1:0]           r_mode;
  logic                    r_enabled;
  logic                    r_match_pulse;
  logic                    r_fail_pulse;
  logic                    r_locked;
  logic [FCW-1:0]          r_fail_cnt;
  logic [TW-1:0]           r_idle_timer;
  logic [LW-1:0]           r_lock_timer;

  logic                    w_digit_key;
  logic                    w_clear_key;
  logic                    w_timeout;
  logic [DCW-1:0]          w_pos;
  logic                    w_match;
  logic [MW-1:0]           w_match_idx;

  assign w_digit_key = bus.key_valid && (bus.key_code != CLEAR_KEY);
  assign w_clear_key = bus.key_valid && (bus.key_code == CLEAR_KEY);
  assign w_timeout   = (r_state == S_ENTRY) && (r_idle_timer == c_timeout_last);

  // A key arriving on the expiry cycle starts a fresh entry at position 0
  always_comb begin
    w_pos = r_digit_count;
    if (w_timeout) begin
      w_pos = '0;
    end
  end

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int k = NUM_CODES - 1; k >= 0; k--) begin
      if (r_buf == bus.codes[k*CODE_LEN*4 +: CODE_LEN*4]) begin
        w_match     = 1'b1;
        w_match_idx = MW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_buf         <= '0;
      r_digit_count <= '0;
      r_mode        <= '0;
      r_enabled     <= 1'b0;
      r_match_pulse <= 1'b0;
      r_fail_pulse  <= 1'b0;
      r_locked      <= 1'b0;
      r_fail_cnt    <= '0;
      r_idle_timer  <= '0;
      r_lock_timer  <= '0;
    end else begin
      r_match_pulse <= 1'b0;
      r_fail_pulse  <= 1'b0;
      case (r_state)
        S_IDLE, S_ENTRY: begin
          if (w_clear_key) begin
            r_digit_count <= '0;
            r_idle_timer  <= '0;
            r_state       <= S_IDLE;
          end else if (w_digit_key) begin
            for (int d = 0; d < CODE_LEN; d++) begin
              if (w_pos == DCW'(d)) begin
                r_buf[d*4 +: 4] <= bus.key_code;
              end
            end
            r_digit_count <= w_pos + 1'b1;
            r_idle_timer  <= '0;
            r_state       <= (w_pos == c_last_digit) ? S_EVAL : S_ENTRY;
          end else if (w_timeout) begin
            r_digit_count <= '0;
            r_idle_timer  <= '0;
            r_state       <= S_IDLE;
          end else if (r_state == S_ENTRY) begin
            r_idle_timer <= r_idle_timer + 1'b1;
          end
        end

        S_EVAL: begin
          r_digit_count <= '0;
          r_idle_timer  <= '0;
          r_state       <= S_IDLE;
          if (w_match) begin
            r_match_pulse <= 1'b1;
            r_fail_cnt    <= '0;
            if ((r_mode == '0) && (w_match_idx != '0)) begin
              r_mode    <= w_match_idx;
              r_enabled <= 1'b1;
            end else if ((r_mode != '0) && (w_match_idx == '0)) begin
              r_mode    <= '0;
              r_enabled <= 1'b0;
            end
          end else begin
            r_fail_pulse <= 1'b1;
            if (r_fail_cnt == c_last_fail) begin
              r_fail_cnt   <= '0;
              r_locked     <= 1'b1;
              r_lock_timer <= '0;
              r_state      <= S_LOCKOUT;
            end else begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
          end
        end

        S_LOCKOUT: begin
          if (r_lock_timer == c_lock_last) begin
            r_locked <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_lock_timer <= r_lock_timer + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.enabled     = r_enabled;
  assign bus.mode        = r_mode;
  assign bus.match_pulse = r_match_pulse;
  assign bus.fail_pulse  = r_fail_pulse;
  assign bus.locked      = r_locked;
  assign bus.digit_count = r_digit_count;

endmodule

`default_nettype wire

// File: tb/tb_keypad_code_lock.sv
// ============================================================================
// Module   : tb_keypad_code_lock
// Purpose  : Directed table-driven bench for keypad_code_lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_code_lock;

  localparam int CODE_LEN  = 4;
  localparam int NUM_CODES = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  keypad_code_lock_if #(.CODE_LEN(CODE_LEN), .NUM_CODES(NUM_CODES)) bus ();

  keypad_code_lock #(
    .CODE_LEN      (CODE_LEN),
    .NUM_CODES     (NUM_CODES),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(16),
    .DIGIT_TIMEOUT (8),
    .CLEAR_KEY     (4'hA),
    .MW            (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] keys;
    logic        m;
    logic        f;
    int          mode;
    logic        en;
    logic        lk;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  // Enters four digits, then waits out EVAL so the result is visible
  task automatic enter(input logic [15:0] keys);
    for (int d = 0; d < 4; d++) press(keys[15-4*d -: 4]);
    tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " mode"},   32'(bus.mode), 0);
    chk({name, " en"},     32'(bus.enabled), 0);
    chk({name, " locked"}, 32'(bus.locked), 0);
    chk({name, " pulses"}, 32'({bus.match_pulse, bus.fail_pulse}), 0);
    chk({name, " dc"},     32'(bus.digit_count), 0);
  endtask

  function automatic vec_t mk(input logic [15:0] k, input logic m, input logic f,
                              input int md, input logic en, input logic lk);
    vec_t v;
    v.keys = k; v.m = m; v.f = f; v.mode = md; v.en = en; v.lk = lk;
    return v;
  endfunction

  initial begin
    logic [15:0] code_digits [3];
    checks = 0;
    errors = 0;
    code_digits[0] = 16'h9999;
    code_digits[1] = 16'h1234;
    code_digits[2] = 16'h4321;

    vecs[0]  = mk(16'h1234, 1, 0, 1, 1, 0);
    vecs[1]  = mk(16'h4321, 1, 0, 1, 1, 0);
    vecs[2]  = mk(16'h9999, 1, 0, 0, 0, 0);
    vecs[3]  = mk(16'h9999, 1, 0, 0, 0, 0);
    vecs[4]  = mk(16'h4321, 1, 0, 2, 1, 0);
    vecs[5]  = mk(16'h9999, 1, 0, 0, 0, 0);
    vecs[6]  = mk(16'h5555, 0, 1, 0, 0, 0);
    vecs[7]  = mk(16'h5555, 0, 1, 0, 0, 0);
    vecs[8]  = mk(16'h1234, 1, 0, 1, 1, 0);
    vecs[9]  = mk(16'h5555, 0, 1, 1, 1, 0);
    vecs[10] = mk(16'h5555, 0, 1, 1, 1, 0);
    vecs[11] = mk(16'h5555, 0, 1, 1, 1, 1);

    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    for (int k = 0; k < NUM_CODES; k++)
      for (int d = 0; d < CODE_LEN; d++)
        bus.codes[(k*CODE_LEN+d)*4 +: 4] = code_digits[k][15-4*d -: 4];

    reset = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Table: enable, disable, fail counting and lockout entry
    for (int i = 0; i < 12; i++) begin
      for (int d = 0; d < 4; d++) begin
        press(vecs[i].keys[15-4*d -: 4]);
        if (d < 3) chk($sformatf("v%0d dc", i), 32'(bus.digit_count), 32'(d + 1));
      end
      tick();
      chk($sformatf("v%0d match", i),  32'(bus.match_pulse), 32'(vecs[i].m));
      chk($sformatf("v%0d fail", i),   32'(bus.fail_pulse),  32'(vecs[i].f));
      chk($sformatf("v%0d mode", i),   32'(bus.mode),        32'(vecs[i].mode));
      chk($sformatf("v%0d en", i),     32'(bus.enabled),     32'(vecs[i].en));
      chk($sformatf("v%0d locked", i), 32'(bus.locked),      32'(vecs[i].lk));
      chk($sformatf("v%0d dc0", i),    32'(bus.digit_count), 0);
      tick();
      chk($sformatf("v%0d pulse1", i), 32'({bus.match_pulse, bus.fail_pulse}), 0);
    end

    // Lockout: keys ignored, unlocks after 16 cycles total
    for (int d = 0; d < 4; d++) begin
      press(d == 3 ? 4'hA : 4'(d + 1));
      chk("lock dc", 32'(bus.digit_count), 0);
      chk("lock pulses", 32'({bus.match_pulse, bus.fail_pulse}), 0);
    end
    for (int i = 0; i < 10; i++) tick();
    chk("lock still", 32'(bus.locked), 1);
    chk("lock mode", 32'(bus.mode), 1);
    tick();
    chk("lock released", 32'(bus.locked), 0);
    enter(16'h1234);
    chk("post-lock match", 32'(bus.match_pulse), 1);
    chk("post-lock mode", 32'(bus.mode), 1);
    enter(16'h9999);
    chk("disable mode", 32'(bus.mode), 0);

    // Timeout discards a partial entry without failing
    press(4'h1);
    press(4'h2);
    chk("to dc2", 32'(bus.digit_count), 2);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to no fail", 32'(bus.fail_pulse), 0);
    end
    chk("to dc before", 32'(bus.digit_count), 2);
    tick();
    chk("to dc after", 32'(bus.digit_count), 0);
    tick();
    chk("to no fail end", 32'(bus.fail_pulse), 0);

    // Clear key in IDLE, then mid-entry
    press(4'hA);
    chk("clr idle dc", 32'(bus.digit_count), 0);
    press(4'h1);
    press(4'h2);
    press(4'hA);
    chk("clr dc", 32'(bus.digit_count), 0);
    tick();
    chk("clr no fail", 32'(bus.fail_pulse), 0);
    enter(16'h1234);
    chk("clr match", 32'(bus.match_pulse), 1);
    chk("clr mode", 32'(bus.mode), 1);

    // Key landing on the expiry cycle starts a fresh entry
    press(4'h5);
    for (int i = 0; i < 7; i++) tick();
    press(4'h1);
    chk("expiry dc", 32'(bus.digit_count), 1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    tick();
    chk("expiry match", 32'(bus.match_pulse), 1);
    chk("expiry fail", 32'(bus.fail_pulse), 0);

    // Async reset mid-entry
    press(4'h1);
    press(4'h2);
    press(4'h3);
    chk("pre-rst dc", 32'(bus.digit_count), 3);
    #2 reset = 1'b0;
    #1 chk_all_zero("rst entry");
    tick();
    reset = 1'b1;
    enter(16'h1234);
    chk("rst1 match", 32'(bus.match_pulse), 1);
    chk("rst1 mode", 32'(bus.mode), 1);

    // Async reset mid-lockout
    enter(16'h5555);
    enter(16'h5555);
    enter(16'h5555);
    chk("rst2 locked", 32'(bus.locked), 1);
    tick();
    tick();
    #2 reset = 1'b0;
    #1 chk_all_zero("rst lock");
    tick();
    reset = 1'b1;
    enter(16'h1234);
    chk("rst2 match", 32'(bus.match_pulse), 1);
    chk("rst2 mode", 32'(bus.mode), 1);
    chk("rst2 en", 32'(bus.enabled), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
